// File: rtl/config_frame_pkg.sv
// Shared constants, FSM state type and CRC helper for the
// configuration frame scheduler.
package config_frame_pkg;

    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;
    localparam logic [7:0]  OP_WRITE  = 8'h01;
    localparam logic [7:0]  OP_END    = 8'h0F;
    localparam logic [31:0] CRC_POLY  = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_SKIP,
        S_STROBE,
        S_CRC
    } state_e;

    // MSB-first CRC-32 over one word, no reflection, no final xor
    function automatic logic [31:0] crc32_word(
        input logic [31:0] crc,
        input logic [31:0] data
    );
        logic [31:0] c;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            if (c[31] ^ data[i])
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            else
                c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/config_frame_scheduler_decoder.sv
// Column/frame address to one-hot FrameStrobe conversion.
// Output is all-zero whenever the enable is low.
module frame_strobe_decoder #(
    parameter int NUM_COLUMNS = 10,
    parameter int MAX_FRAMES  = 20
) (
    input  logic [7:0]                        col_i,
    input  logic [4:0]                        frame_i,
    input  logic                              en_i,
    output logic [NUM_COLUMNS*MAX_FRAMES-1:0] strobe_o
);

    localparam int W = NUM_COLUMNS * MAX_FRAMES;

    logic [31:0] idx;

    // Flat bit index col*MAX_FRAMES+frame, one bit set when enabled
    always_comb begin
        idx      = 32'(col_i) * 32'(MAX_FRAMES) + 32'(frame_i);
        strobe_o = '0;
        for (int i = 0; i < W; i++) begin
            if (en_i && (idx == 32'(i)))
                strobe_o[i] = 1'b1;
        end
    end

endmodule

// File: rtl/config_frame_scheduler.sv
// Bitstream word stream to FABulous frame writes.
// Optional CRC check of the loaded data: define CONFIG_FRAME_CRC_EN.
module config_frame_scheduler
    import config_frame_pkg::*;
#(
    parameter int NUM_ROWS    = 16,
    parameter int NUM_COLUMNS = 10,
    parameter int MAX_FRAMES  = 20
) (
    input  logic                              CLK,
    input  logic                              resetn,
    input  logic [31:0]                       s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic [NUM_ROWS*32-1:0]            FrameData,
    output logic [NUM_COLUMNS*MAX_FRAMES-1:0] FrameStrobe,
    output logic                              busy,
    output logic                              done,
    output logic                              err
`ifdef CONFIG_FRAME_CRC_EN
    ,
    output logic                              crc_err
`endif
);

    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
    localparam logic [31:0] NCOL = 32'(NUM_COLUMNS);
    localparam logic [31:0] NFRM = 32'(MAX_FRAMES);

    state_e        state_q;
    logic          s_ready_q;
    logic          done_q;
    logic          err_q;
    logic [RW-1:0] row_cnt_q;
    logic [7:0]    col_q;
    logic [4:0]    frame_q;
    logic [31:0]   rows_q [NUM_ROWS];

`ifdef CONFIG_FRAME_CRC_EN
    logic [31:0]   crc_q;
    logic          crc_err_q;
`endif

    logic          acc;
    logic [7:0]    opcode;
    logic          is_write;
    logic          is_end;
    logic          addr_ok;
    logic          unused_bits;

    assign acc      = s_valid & s_ready_q;
    assign opcode   = s_data[31:24];
    assign is_write = (opcode == OP_WRITE);
    assign is_end   = (opcode == OP_END);
    assign addr_ok  = ({24'd0, s_data[23:16]} < NCOL)
                   && ({27'd0, s_data[4:0]} < NFRM);
    assign unused_bits = ^s_data[15:5];

    // Packet sequencer: header decode, row fill, strobe, sticky flags
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            s_ready_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            row_cnt_q <= '0;
            col_q     <= '0;
            frame_q   <= '0;
            for (int r = 0; r < NUM_ROWS; r++)
                rows_q[r] <= '0;
`ifdef CONFIG_FRAME_CRC_EN
            crc_q     <= CRC_INIT;
            crc_err_q <= 1'b0;
`endif
        end else begin
            s_ready_q <= 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (acc && (s_data == SYNC_WORD)) begin
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= S_HDR;
`ifdef CONFIG_FRAME_CRC_EN
                        crc_q     <= CRC_INIT;
                        crc_err_q <= 1'b0;
`endif
                    end
                end
                S_HDR: begin
                    if (acc) begin
                        row_cnt_q <= '0;
                        unique case (1'b1)
                            is_write && addr_ok: begin
                                col_q   <= s_data[23:16];
                                frame_q <= s_data[4:0];
                                state_q <= S_DATA;
                            end
                            is_write && !addr_ok: begin
                                err_q   <= 1'b1;
                                state_q <= S_SKIP;
                            end
                            is_end: begin
`ifdef CONFIG_FRAME_CRC_EN
                                state_q <= S_CRC;
`else
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
`endif
                            end
                            default: begin
                                err_q   <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_DATA: begin
                    if (acc) begin
                        rows_q[row_cnt_q] <= s_data;
`ifdef CONFIG_FRAME_CRC_EN
                        crc_q <= crc32_word(crc_q, s_data);
`endif
                        if (row_cnt_q == LAST_ROW) begin
                            row_cnt_q <= '0;
                            s_ready_q <= 1'b0;
                            state_q   <= S_STROBE;
                        end else begin
                            row_cnt_q <= row_cnt_q + RW'(1);
                        end
                    end
                end
                S_SKIP: begin
                    if (acc) begin
                        if (row_cnt_q == LAST_ROW) begin
                            row_cnt_q <= '0;
                            state_q   <= S_HDR;
                        end else begin
                            row_cnt_q <= row_cnt_q + RW'(1);
                        end
                    end
                end
                S_STROBE: begin
                    state_q <= S_HDR;
                end
`ifdef CONFIG_FRAME_CRC_EN
                S_CRC: begin
                    if (acc) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                        if (s_data != crc_q) begin
                            err_q     <= 1'b1;
                            crc_err_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Row registers flattened onto the frame data bus, row 0 lowest
    for (genvar g = 0; g < NUM_ROWS; g++) begin : g_rows
        assign FrameData[g*32 +: 32] = rows_q[g];
    end

    frame_strobe_decoder #(
        .NUM_COLUMNS (NUM_COLUMNS),
        .MAX_FRAMES  (MAX_FRAMES)
    ) u_dec (
        .col_i    (col_q),
        .frame_i  (frame_q),
        .en_i     (state_q == S_STROBE),
        .strobe_o (FrameStrobe)
    );

    assign s_ready = s_ready_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign err     = err_q;
`ifdef CONFIG_FRAME_CRC_EN
    assign crc_err = crc_err_q;
`endif

endmodule

// File: tb/tb_config_frame_scheduler.sv
// Directed bench for config_frame_scheduler.
// CRC steps compile in when CONFIG_FRAME_CRC_EN is defined.
module tb_config_frame_scheduler;

    localparam int NR = 16;
    localparam int NC = 10;
    localparam int MF = 20;

    logic           CLK = 1'b0;
    logic           resetn = 1'b0;
    logic [31:0]    s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [NR*32-1:0] FrameData;
    logic [NC*MF-1:0] FrameStrobe;
    logic           busy;
    logic           done;
    logic           err;
`ifdef CONFIG_FRAME_CRC_EN
    logic           crc_err;
`endif

    int tests = 0;
    int fails = 0;
    int strobe_cycles = 0;
    int multi_hot = 0;
    int ready_in_strobe = 0;

    logic [NC*MF-1:0] exp_s;
    logic [NR*32-1:0] exp_d;

    config_frame_scheduler #(
        .NUM_ROWS    (NR),
        .NUM_COLUMNS (NC),
        .MAX_FRAMES  (MF)
    ) dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .done        (done),
        .err         (err)
`ifdef CONFIG_FRAME_CRC_EN
        ,
        .crc_err     (crc_err)
`endif
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (FrameStrobe != '0) begin
            strobe_cycles++;
            if (!$onehot(FrameStrobe)) multi_hot++;
            if (s_ready) ready_in_strobe++;
        end
    end

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Offer one word at a negedge; returns at the negedge after acceptance
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: observed s_ready=0 expected 1");
        end
        @(negedge CLK);
        s_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    function automatic logic [31:0] crc_model(input logic [31:0] c,
                                              input logic [31:0] d);
        logic [31:0] r;
        r = c ^ d;
        for (int k = 0; k < 32; k++)
            r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
        return r;
    endfunction

`ifdef CONFIG_FRAME_CRC_EN
    task automatic crc_run(input logic [31:0] flip);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        send(32'hFAB0_FAB1);
        send(32'h0101_0002);
        for (int i = 0; i < NR; i++) begin
            send(32'hC0DE_0000 + 32'(i));
            c = crc_model(c, 32'hC0DE_0000 + 32'(i));
        end
        @(negedge CLK);
        send(32'h0102_0003);
        for (int i = 0; i < NR; i++) begin
            send(32'h1234_5678 ^ 32'(i * 7));
            c = crc_model(c, 32'h1234_5678 ^ 32'(i * 7));
        end
        @(negedge CLK);
        send(32'h0F00_0000);
        send(c ^ flip);
    endtask
`endif

    initial begin
        // Reset state
        #2;
        chk("rst_data", FrameData, '0);
        chk("rst_strobe", FrameStrobe, '0);
        chk("rst_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        gap(2);
        resetn = 1'b1;
        @(negedge CLK);
        chk("idle_ready", s_ready, 1);

        // Frame to col 3, frame 5
        send(32'hFAB0_FAB1);
        send(32'h0103_0005);
        send(32'd0);
        send(32'd1);
        chk("data_latency", FrameData[63:32], 32'd1);
        for (int i = 2; i < NR; i++) send(32'(i));
        exp_s = '0;
        exp_s[65] = 1'b1;
        chk("strobe65", FrameStrobe, exp_s);
        chk("strobe_ready", s_ready, 0);
        chk("strobe_busy", busy, 1);
        @(negedge CLK);
        chk("strobe_one_cycle", FrameStrobe, '0);
        chk("hdr_ready", s_ready, 1);
        chk("row0", FrameData[31:0], 32'd0);
        chk("row15", FrameData[511:480], 32'd15);
        chk("hdr_busy", busy, 1);
        chk("strobe_cnt1", strobe_cycles, 1);

        // END sets done; SYNC clears it
        send(32'h0F00_0000);
        chk("end_done", done, 1);
        chk("end_idle", busy, 0);
        send(32'hFAB0_FAB1);
        chk("sync_clr_done", done, 0);

        // Out-of-range column
        send(32'h010A_0000);
        chk("bad_col_err", err, 1);
        for (int i = 0; i < NR; i++) send(32'hA5A5_0000 + 32'(i));
        send(32'h0F00_0000);
        chk("skip_done", done, 1);
        chk("skip_err", err, 1);
        chk("skip_no_strobe", strobe_cycles, 1);
        chk("skip_data_kept", FrameData[31:0], 32'd0);

        // Frame with valid gaps, col 9 frame 19
        send(32'hFAB0_FAB1);
        chk("sync_clr_err", err, 0);
        send(32'h0109_0013);
        exp_d = '0;
        for (int i = 0; i < NR; i++) begin
            gap($urandom_range(0, 2));
            send(32'h1000 + 32'(i * 17));
            exp_d[i*32 +: 32] = 32'h1000 + 32'(i * 17);
        end
        exp_s = '0;
        exp_s[199] = 1'b1;
        chk("gap_strobe", FrameStrobe, exp_s);
        chk("gap_ready0", s_ready, 0);
        @(negedge CLK);
        chk("gap_data", FrameData, exp_d);
        chk("gap_strobe_cnt", strobe_cycles, 2);

        // Reset mid-frame
        send(32'h0100_0000);
        for (int i = 0; i < 7; i++) send(32'h2000 + 32'(i));
        resetn = 1'b0;
        #1;
        chk("mid_rst_data", FrameData, '0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", s_ready, 0);
        chk("mid_rst_strobe", FrameStrobe, '0);
        @(negedge CLK);
        resetn = 1'b1;
        @(negedge CLK);
        send(32'hFAB0_FAB1);
        send(32'h0100_0000);
        exp_d = '0;
        for (int i = 0; i < NR; i++) begin
            send(32'h3000 + 32'(i));
            exp_d[i*32 +: 32] = 32'h3000 + 32'(i);
        end
        exp_s = '0;
        exp_s[0] = 1'b1;
        chk("rst_reload_strobe", FrameStrobe, exp_s);
        @(negedge CLK);
        chk("rst_reload_data", FrameData, exp_d);
        chk("rst_strobe_cnt", strobe_cycles, 3);

        // Bad opcode, then words ignored in IDLE
        send(32'h2200_0000);
        chk("badop_err", err, 1);
        chk("badop_idle", busy, 0);
        send(32'h0103_0005);
        for (int i = 0; i < NR; i++) send(32'h5000 + 32'(i));
        gap(2);
        chk("ignored_busy", busy, 0);
        chk("ignored_strobe", strobe_cycles, 3);
        chk("ignored_data", FrameData, exp_d);

`ifdef CONFIG_FRAME_CRC_EN
        crc_run(32'd0);
        chk("crc_ok_done", done, 1);
        chk("crc_ok_flag", crc_err, 0);
        chk("crc_ok_err", err, 0);
        crc_run(32'd1);
        chk("crc_bad_done", done, 1);
        chk("crc_bad_flag", crc_err, 1);
        chk("crc_bad_err", err, 1);
`endif

        chk("onehot", multi_hot, 0);
        chk("ready_low_in_strobe", ready_in_strobe, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
